serial_subtractor_ctrl: RTL and testbench

Bit-serial subtractor controller that computes A − B − Bin for WIDTH-bit operands using a single full-subtractor cell, one bit per clock, LSB first. The controller holds the operands in shift registers, keeps the inter-bit borrow in a flop, counts bit positions and reports the result with a start/done handshake. It is the sequencing wrapper that turns the one-bit full-subtractor datapath into a multi-bit arithmetic unit.

---
 rtl/serial_subtractor_ctrl.sv | 110 +++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: A - B - Bin, one full-subtractor step per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d_bit, bo_bit, last;

  function automatic logic fs_diff(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic c);
    return (~a & b) | (~(a ^ b) & c);
  endfunction

  always_comb begin
    d_bit  = fs_diff(a_sh[0], b_sh[0], borrow);
    bo_bit = fs_borrow(a_sh[0], b_sh[0], borrow);
    // New bit enters at the MSB; after WIDTH steps bit 0 has reached position 0.
    res_nx = (res_sh >> 1) | ({{(WIDTH-1){1'b0}}, d_bit} << (WIDTH-1));
    last   = (state == RUN) && (cnt == CW'(WIDTH-1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          borrow <= bo_bit;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nx;
          cnt    <= cnt + 1'b1;
          if (last) begin
            diff <= res_nx;
            bout <= bo_bit;
`ifdef SERIAL_SUB_OVF_EN
            // Signed overflow: borrow into the sign bit differs from borrow out of it.
            ovf  <= borrow ^ bo_bit;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN) || (state == DONE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed self-checking bench for serial_subtractor_ctrl (WIDTH=8).
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       bin = 1'b0;
  logic       ready, busy, done, bout;
  logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Launch one operation from IDLE; lat = edges from accept to observed done, -1 on timeout.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output int lat);
    int n;
    lat = -1;
    for (n = 0; n < 20 && !ready; n++) begin
      @(posedge clk); #1;
    end
    if (!ready) return;
    start = 1'b1; a_in = a; b_in = b; bin = bi;
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (diff !== 8'h00 || bout !== 1'b0) begin errors++; $display("FAIL reset_diff got=%h/%b exp=00/0", diff, bout); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    do_op(8'h5A, 8'h3C, 1'b0, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++; if (diff !== 8'h1E || bout !== 1'b0) begin errors++; $display("FAIL basic_5A_3C got=%h/%b exp=1e/0", diff, bout); end
    checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_done_state got=r%b b%b exp=r0 b1", ready, busy); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_ready_back got=r%b d%b b%b exp=r1 d0 b0", ready, done, busy); end
  endtask

  task automatic test_borrow();
    int lat;
    do_op(8'h00, 8'h01, 1'b0, lat);
    checks++; if (lat !== 8 || diff !== 8'hFF || bout !== 1'b1) begin errors++; $display("FAIL borrow_00_01 got=%h/%b lat=%0d exp=ff/1 lat=8", diff, bout, lat); end
    do_op(8'h00, 8'h00, 1'b1, lat);
    checks++; if (lat !== 8 || diff !== 8'hFF || bout !== 1'b1) begin errors++; $display("FAIL borrow_bin got=%h/%b lat=%0d exp=ff/1 lat=8", diff, bout, lat); end
    do_op(8'h80, 8'h01, 1'b0, lat);
    checks++; if (diff !== 8'h7F || bout !== 1'b0) begin errors++; $display("FAIL ovf_case_80_01 got=%h/%b exp=7f/0", diff, bout); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf); end
`endif
    do_op(8'h10, 8'h01, 1'b0, lat);
    checks++; if (diff !== 8'h0F || bout !== 1'b0) begin errors++; $display("FAIL ovf_case_10_01 got=%h/%b exp=0f/0", diff, bout); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
`endif
  endtask

  task automatic test_ignore_start();
    int n;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; a_in = 8'h33; b_in = 8'h11; bin = 1'b0;
    @(posedge clk); #1;
    // Stray request with different operands while RUN.
    a_in = 8'hFF; b_in = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL ignore_done_timeout got=none exp=done"); end
    checks++; if (diff !== 8'h22 || bout !== 1'b0) begin errors++; $display("FAIL ignore_result got=%h/%b exp=22/0", diff, bout); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ignore_in_done got=r%b b%b exp=r1 b0", ready, busy); end
    for (int i = 0; i < 5; i++) begin
      a_in = 8'(i * 37); b_in = 8'(i * 11);
      @(posedge clk); #1;
    end
    checks++; if (diff !== 8'h22 || busy !== 1'b0) begin errors++; $display("FAIL ignore_hold got=%h b%b exp=22 b0", diff, busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit seen;
    start = 1'b1; a_in = 8'hAB; b_in = 8'h12; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || diff !== 8'h00 || bout !== 1'b0)
      begin errors++; $display("FAIL midrun_reset got=r%b b%b diff=%h bo=%b exp=r1 b0 00 0", ready, busy, diff, bout); end
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL midrun_no_done got=done exp=none"); end
    do_op(8'h09, 8'h04, 1'b0, lat);
    checks++; if (lat !== 8 || diff !== 8'h05 || bout !== 1'b0) begin errors++; $display("FAIL after_reset got=%h/%b lat=%0d exp=05/0 lat=8", diff, bout, lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [4] = '{8'h5A, 8'h12, 8'hF0, 8'hFF};
    logic [7:0] tb [4] = '{8'h3C, 8'h34, 8'h0F, 8'hFF};
    logic       tbi[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ed [3] = '{8'h1E, 8'hDD, 8'hE1};
    logic       eb [3] = '{1'b0, 1'b1, 1'b0};
    int k;
    @(posedge clk); #1;
    k = 0;
    start = 1'b1; a_in = ta[0]; b_in = tb[0]; bin = tbi[0];
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c % 10 == 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept c=%0d got=%b exp=1", c, busy); end
        a_in = ta[c/10 + 1]; b_in = tb[c/10 + 1]; bin = tbi[c/10 + 1];
      end
      if (done) begin
        if (k < 3) begin
          checks++; if (c !== 10*k + 8 || diff !== ed[k] || bout !== eb[k])
            begin errors++; $display("FAIL b2b_op%0d got=c%0d %h/%b exp=c%0d %h/%b", k, c, diff, bout, 10*k+8, ed[k], eb[k]); end
        end
        k++;
      end
    end
    start = 1'b0;
    checks++; if (k !== 3) begin errors++; $display("FAIL b2b_done_count got=%0d exp=3", k); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
